pagerank_partition_scheduler: RTL and testbench

- Sequences PageRank iterations over a partitioned graph by dispatching partition indices to a pool of hardware worker threads.
- Shares the partition work queue between threads using round-robin arbitration.
- Collects per-partition delta reports, decides convergence against a threshold, and repeats iterations up to a maximum count.
- Sits between the top-level enable/status interface and the per-thread pagerank compute engines.

---
 rtl/pagerank_partition_scheduler_if.sv | 34 +++
 rtl/pagerank_partition_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_pagerank_partition_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pagerank_partition_scheduler_if.sv
// Thread-side bus between the PageRank partition scheduler and its worker
// threads: partition requests and grants in one direction, completion reports
// (valid + delta) in the other.
interface pagerank_partition_scheduler_if #(
  parameter int NUM_HW_THREADS = 4,
  parameter int NUM_PARTITIONS = 20,
  parameter int DELTA_W        = 32
);
  localparam int PART_W = (NUM_PARTITIONS > 1) ? $clog2(NUM_PARTITIONS) : 1;

  logic [NUM_HW_THREADS-1:0]         thread_req;
  logic [NUM_HW_THREADS-1:0]         grant;
  logic [PART_W-1:0]                 grant_partition;
  logic [NUM_HW_THREADS-1:0]         done_valid;
  logic [NUM_HW_THREADS*DELTA_W-1:0] done_delta;

  // Scheduler side: hands out partitions, collects completions.
  modport master (
    input  thread_req,
    input  done_valid,
    input  done_delta,
    output grant,
    output grant_partition
  );

  // Worker-thread side.
  modport slave (
    output thread_req,
    output done_valid,
    output done_delta,
    input  grant,
    input  grant_partition
  );
endinterface

// File: rtl/pagerank_partition_scheduler.sv
// PageRank partition scheduler.
// Runs PageRank iterations over a partitioned graph: every iteration hands
// each partition index to one idle worker thread (round-robin between
// requesting threads), waits for all of them to report their delta, then
// either stops (converged or iteration cap reached) or starts the next pass.
module pagerank_partition_scheduler #(
  parameter int NUM_HW_THREADS = 4,
  parameter int NUM_PARTITIONS = 20,
  parameter int MAX_ITER       = 64,
  parameter int DELTA_W        = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [DELTA_W-1:0]            threshold,
  pagerank_partition_scheduler_if.master thread_bus,
  output logic [$clog2(MAX_ITER+1)-1:0] iteration,
  output logic [DELTA_W-1:0]            max_delta,
  output logic                          busy,
  output logic                          complete,
  output logic                          converged
);

  localparam int N      = NUM_HW_THREADS;
  localparam int PTR_W  = (N > 1) ? $clog2(N) : 1;
  localparam int PART_W = (NUM_PARTITIONS > 1) ? $clog2(NUM_PARTITIONS) : 1;
  localparam int PCNT_W = $clog2(NUM_PARTITIONS + 1);
  localparam int ITER_W = $clog2(MAX_ITER + 1);

  localparam logic [PCNT_W-1:0] PART_END    = PCNT_W'(NUM_PARTITIONS);
  localparam logic [ITER_W-1:0] LAST_ITER   = ITER_W'(MAX_ITER - 1);
  localparam logic [PTR_W-1:0]  LAST_THREAD = PTR_W'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    DISPATCH,
    DRAIN,
    CHECK,
    DONE
  } state_t;

  state_t              state;
  logic [N-1:0]        outstanding;
  logic [PCNT_W-1:0]   next_part;
  logic [PTR_W-1:0]    rr_ptr;
  logic [DELTA_W-1:0]  thr_q;

  logic [N-1:0]        eligible;
  logic [N-1:0]        done_hit;
  logic [N-1:0]        out_cleared;
  logic [N-1:0]        win_onehot;
  logic [PTR_W:0]      pick;
  logic                win_found;
  logic [PTR_W-1:0]    win_idx;
  logic                can_grant;
  logic [DELTA_W-1:0]  delta_merged;

  // Round-robin pick: lowest eligible thread at or above the pointer,
  // otherwise the lowest eligible thread overall (wrap-around).
  // Returns {any_eligible, winner_index}.
  function automatic logic [PTR_W:0] rr_pick(input logic [N-1:0]     elig,
                                             input logic [PTR_W-1:0] ptr);
    logic [N-1:0]     upper;
    logic [N-1:0]     src;
    logic [PTR_W-1:0] idx;
    upper = elig & ~((N'(1) << ptr) - N'(1));
    src   = (upper != '0) ? upper : elig;
    idx   = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (src[j]) idx = PTR_W'(j);
    end
    return {(elig != '0), idx};
  endfunction

  // Pointer position just past a winner, modulo the thread count.
  function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] idx);
    return (idx == LAST_THREAD) ? '0 : idx + PTR_W'(1);
  endfunction

  // Running maximum folded with every accepted delta reported this cycle.
  function automatic logic [DELTA_W-1:0] merge_max(
    input logic [N-1:0]         hit,
    input logic [N*DELTA_W-1:0] deltas,
    input logic [DELTA_W-1:0]   seed
  );
    logic [DELTA_W-1:0] m;
    logic [DELTA_W-1:0] d;
    m = seed;
    for (int i = 0; i < N; i++) begin
      d = deltas[i*DELTA_W +: DELTA_W];
      if (hit[i] && (d > m)) m = d;
    end
    return m;
  endfunction

  // Arbitration and completion bookkeeping for the current cycle.
  always_comb begin
    eligible     = thread_bus.thread_req & ~outstanding;
    done_hit     = thread_bus.done_valid & outstanding;
    out_cleared  = outstanding & ~thread_bus.done_valid;
    pick         = rr_pick(eligible, rr_ptr);
    win_found    = pick[PTR_W];
    win_idx      = pick[PTR_W-1:0];
    win_onehot   = N'(1) << win_idx;
    can_grant    = (state == DISPATCH) && (next_part < PART_END) && win_found;
    delta_merged = merge_max(done_hit, thread_bus.done_delta, max_delta);
  end

  // Scheduler FSM with registered grant and status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                      <= IDLE;
      thread_bus.grant           <= '0;
      thread_bus.grant_partition <= '0;
      iteration                  <= '0;
      max_delta                  <= '0;
      busy                       <= 1'b0;
      complete                   <= 1'b0;
      converged                  <= 1'b0;
      outstanding                <= '0;
      next_part                  <= '0;
      rr_ptr                     <= '0;
      thr_q                      <= '0;
    end else begin
      // Grants are single-cycle pulses; completions are accepted in any state
      // (outside DISPATCH/DRAIN nothing is outstanding, so they are no-ops).
      thread_bus.grant <= '0;
      outstanding      <= out_cleared | (can_grant ? win_onehot : '0);
      max_delta        <= delta_merged;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= DISPATCH;
            thr_q     <= threshold;
            iteration <= '0;
            max_delta <= '0;
            next_part <= '0;
            busy      <= 1'b1;
            complete  <= 1'b0;
            converged <= 1'b0;
          end
        end

        DISPATCH: begin
          if (can_grant) begin
            thread_bus.grant           <= win_onehot;
            thread_bus.grant_partition <= next_part[PART_W-1:0];
            next_part                  <= next_part + PCNT_W'(1);
            rr_ptr                     <= ptr_after(win_idx);
          end
          if (next_part == PART_END) state <= DRAIN;
        end

        DRAIN: begin
          // Completions arriving this very cycle count toward the drain.
          if (out_cleared == '0) state <= CHECK;
        end

        CHECK: begin
          if (max_delta < thr_q) begin
            state     <= DONE;
            busy      <= 1'b0;
            complete  <= 1'b1;
            converged <= 1'b1;
          end else if (iteration == LAST_ITER) begin
            state     <= DONE;
            busy      <= 1'b0;
            complete  <= 1'b1;
            converged <= 1'b0;
          end else begin
            state     <= DISPATCH;
            iteration <= iteration + ITER_W'(1);
            max_delta <= '0;
            next_part <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pagerank_partition_scheduler.sv
// Self-checking bench for pagerank_partition_scheduler: a table of whole-run
// vectors plus hand-written sequences for simultaneous completions, spurious
// completions and reset in the middle of a drain.
module tb_pagerank_partition_scheduler;
  localparam int NT = 4;
  localparam int NP = 8;
  localparam int MI = 4;
  localparam int DW = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [DW-1:0]     threshold;
  logic [NT-1:0]     req;
  logic [NT-1:0]     man_dv;
  logic [NT-1:0]     auto_dv;
  logic [NT-1:0]     hold;
  logic [NT*DW-1:0]  man_dd;
  logic [NT*DW-1:0]  dd_c;
  logic [DW-1:0]     auto_delta;
  logic [2:0]        iteration;
  logic [DW-1:0]     max_delta;
  logic              busy;
  logic              complete;
  logic              converged;

  int                n_cmp = 0;
  int                n_bad = 0;
  int                n_grants;
  int                exp_part;
  int                lat;
  int                cnt[NT];
  int                glog[8];
  logic [NT-1:0]     out_m;

  typedef struct {
    logic [31:0] thr;
    logic [31:0] delta;
    logic        conv;
    int          iter;
    logic [31:0] maxd;
    int          grants;
  } vec_t;

  vec_t vecs[5];

  pagerank_partition_scheduler_if #(
    .NUM_HW_THREADS(NT), .NUM_PARTITIONS(NP), .DELTA_W(DW)
  ) bus ();

  pagerank_partition_scheduler #(
    .NUM_HW_THREADS(NT), .NUM_PARTITIONS(NP), .MAX_ITER(MI), .DELTA_W(DW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .threshold  (threshold),
    .thread_bus (bus),
    .iteration  (iteration),
    .max_delta  (max_delta),
    .busy       (busy),
    .complete   (complete),
    .converged  (converged)
  );

  always #5 clock = ~clock;

  assign bus.thread_req = req;
  assign bus.done_valid = auto_dv | man_dv;

  always_comb begin
    dd_c = '0;
    for (int i = 0; i < NT; i++)
      dd_c[i*DW +: DW] = man_dv[i] ? man_dd[i*DW +: DW] : auto_delta;
  end
  assign bus.done_delta = dd_c;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, want);
    end
  endtask

  // One clock: sample just after the edge, check any grant, model the
  // outstanding set, and run the auto-responding worker threads.
  task automatic step();
    @(posedge clock);
    #1;
    if (reset) begin
      out_m   = '0;
      auto_dv = '0;
      for (int i = 0; i < NT; i++) cnt[i] = 0;
      return;
    end
    if (bus.grant != '0) begin
      check("grant_onehot", 32'($onehot(bus.grant)), 32'd1);
      check("grant_outstanding", 32'(bus.grant & out_m), 32'd0);
      check("grant_partition", 32'(bus.grant_partition), 32'(exp_part));
      exp_part = (exp_part + 1) % NP;
      for (int i = 0; i < NT; i++)
        if (bus.grant[i] && n_grants < 8) glog[n_grants] = i;
      n_grants++;
    end
    out_m = (out_m & ~bus.done_valid) | bus.grant;
    for (int i = 0; i < NT; i++) begin
      auto_dv[i] = 1'b0;
      if (cnt[i] != 0) begin
        cnt[i]--;
        if (cnt[i] == 0) auto_dv[i] = 1'b1;
      end
      if (bus.grant[i] && !hold[i]) cnt[i] = lat;
    end
  endtask

  task automatic wait_complete(input int budget);
    int k;
    logic [2:0] prev;
    prev = iteration;
    k = 0;
    while (!complete && k < budget) begin
      step();
      k++;
      if (iteration != prev) begin
        check("iter_step", 32'(iteration), 32'(prev) + 32'd1);
        check("iter_maxd_clear", max_delta, 32'd0);
        prev = iteration;
      end
    end
    if (!complete) check("complete_timeout", 32'(complete), 32'd1);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    man_dv = '0;
    req    = '0;
    step();
    reset  = 1'b0;
    step();
    n_grants = 0;
    exp_part = 0;
  endtask

  task automatic run_vector(input int v);
    hold       = '0;
    lat        = 3;
    req        = '1;
    auto_delta = vecs[v].delta;
    threshold  = vecs[v].thr;
    n_grants   = 0;
    exp_part   = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("v_busy_after_start", 32'(busy), 32'd1);
    check("v_complete_cleared", 32'(complete), 32'd0);
    repeat (5) step();
    check("v_busy_mid", 32'(busy), 32'd1);
    // A start while busy and a changed threshold must both be ignored.
    threshold = ~vecs[v].thr;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_complete(1000);
    check("v_converged", 32'(converged), 32'(vecs[v].conv));
    check("v_iteration", 32'(iteration), 32'(vecs[v].iter));
    check("v_max_delta", max_delta, vecs[v].maxd);
    check("v_busy_done", 32'(busy), 32'd0);
    check("v_grants", 32'(n_grants), 32'(vecs[v].grants));
    if (v == 0)
      for (int k = 0; k < 5; k++) check("rr_order", 32'(glog[k]), 32'(k % NT));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; threshold = '0; req = '0;
    man_dv = '0; man_dd = '0; auto_dv = '0; auto_delta = '0;
    hold = '0; lat = 3; out_m = '0; n_grants = 0; exp_part = 0;
    for (int i = 0; i < NT; i++) cnt[i] = 0;
    for (int i = 0; i < 8; i++) glog[i] = -1;

    vecs[0] = '{32'h100,   32'h0,     1'b1, 0, 32'h0,     8};
    vecs[1] = '{32'h10000, 32'h20000, 1'b0, 3, 32'h20000, 32};
    vecs[2] = '{32'h10000, 32'h10000, 1'b0, 3, 32'h10000, 32};
    vecs[3] = '{32'h10001, 32'h10000, 1'b1, 0, 32'h10000, 8};
    vecs[4] = '{32'h0,     32'h0,     1'b0, 3, 32'h0,     32};

    // Reset state
    step();
    step();
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_grant_partition", 32'(bus.grant_partition), 32'd0);
    check("rst_iteration", 32'(iteration), 32'd0);
    check("rst_max_delta", max_delta, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_complete", 32'(complete), 32'd0);
    check("rst_converged", 32'(converged), 32'd0);
    reset = 1'b0;
    step();
    check("idle_busy", 32'(busy), 32'd0);

    for (int v = 0; v < 5; v++) run_vector(v);

    // Simultaneous completions on threads 1 and 3, then a spurious one on 2.
    do_reset();
    hold = '1;
    req = 4'b1010;
    threshold = '1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 20 && n_grants < 2; k++) step();
    check("a_two_grants", 32'(n_grants), 32'd2);
    req = '0;
    check("a_first_thread", 32'(glog[0]), 32'd1);
    check("a_second_thread", 32'(glog[1]), 32'd3);
    man_dd = '0;
    man_dd[1*DW +: DW] = 32'h500;
    man_dd[3*DW +: DW] = 32'h900;
    man_dv = 4'b1010;
    step();
    man_dv = '0;
    check("a_dual_max", max_delta, 32'h900);
    man_dd[2*DW +: DW] = 32'hFFFF;
    man_dv = 4'b0100;
    step();
    man_dv = '0;
    check("a_spurious_ignored", max_delta, 32'h900);
    check("a_busy", 32'(busy), 32'd1);
    hold = '0;
    auto_delta = '0;
    req = '1;
    wait_complete(1000);
    check("a_converged", 32'(converged), 32'd1);
    check("a_iteration", 32'(iteration), 32'd0);
    check("a_max_delta", max_delta, 32'h900);
    check("a_grants", 32'(n_grants), 32'd8);

    // Reset while draining with threads 0 and 1 still outstanding.
    do_reset();
    hold = 4'b0011;
    lat = 3;
    req = '1;
    auto_delta = 32'h40;
    threshold = '1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 100 && n_grants < NP; k++) step();
    check("b_all_dispatched", 32'(n_grants), 32'(NP));
    repeat (6) step();
    check("b_busy_drain", 32'(busy), 32'd1);
    check("b_complete_drain", 32'(complete), 32'd0);
    check("b_max_drain", max_delta, 32'h40);
    #3 reset = 1'b1;
    #1;
    check("b_rst_grant", 32'(bus.grant), 32'd0);
    check("b_rst_max_delta", max_delta, 32'd0);
    check("b_rst_busy", 32'(busy), 32'd0);
    check("b_rst_complete", 32'(complete), 32'd0);
    check("b_rst_iteration", 32'(iteration), 32'd0);
    step();
    reset = 1'b0;
    man_dd = '0;
    man_dd[0*DW +: DW] = 32'h1234;
    man_dd[1*DW +: DW] = 32'h1234;
    man_dv = 4'b0011;
    step();
    man_dv = '0;
    check("b_late_done_ignored", max_delta, 32'd0);
    check("b_idle_busy", 32'(busy), 32'd0);
    repeat (3) step();
    check("b_no_regrant", 32'(n_grants), 32'(NP));
    hold = '0;
    auto_delta = '0;
    threshold = 32'h100;
    exp_part = 0;
    n_grants = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("b_restart_grant", 32'(bus.grant), 32'd1);
    check("b_restart_part", 32'(bus.grant_partition), 32'd0);
    check("b_restart_iter", 32'(iteration), 32'd0);
    wait_complete(1000);
    check("b_converged", 32'(converged), 32'd1);
    check("b_iteration", 32'(iteration), 32'd0);
    check("b_max_delta", max_delta, 32'd0);
    check("b_grants", 32'(n_grants), 32'(NP));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
